fetch_buffer: RTL
=================

// Module: fetch_buffer
// PURPOSE
//   Consumer end of the program counter's fetch interface.
//   - Accepts the PC presented to instruction memory each cycle.
//   - Pairs that PC with the IMEM read data returned one cycle later.
//   - Queues {pc, instr} pairs for decode behind a valid/ready handshake.
//   - Drives the PC's stall input for backpressure, and discards all
//     queued and in-flight fetches on a redirect flush.
// PARAMETERS
//   DEPTH   4   queue entries; power of two, >= 2
//   (local) PTR_W = log2(DEPTH); CNT_W = PTR_W+1
// PORTS
//   clk         in   1   clock; all state updates on the rising edge
//   rst         in   1   reset, asynchronous, active-low (0 = in reset)
//   fetch_pc    in   32  PC driven to IMEM this cycle (program counter pc_out)
//   imem_rdata  in   32  IMEM read data for the PC accepted in the previous cycle
//   flush       in   1   redirect/target taken this cycle; fetch_pc is the new target
//   stall       out  1   1 = fetch_pc not accepted this cycle; PC must hold
//   dec_valid   out  1   queue head holds a valid {pc, instr}
//   dec_ready   in   1   decode consumes the head when dec_valid & dec_ready
//   dec_pc      out  32  PC of head entry
//   dec_instr   out  32  instruction of head entry
//   occupancy   out  CNT_W  entries currently queued (0..DEPTH)
// BEHAVIOUR
//   Reset (rst=0, asynchronous): count=0, rd/wr pointers=0, infl_v=0,
//     infl_pc=0, all storage=0. Outputs: dec_valid=0, dec_pc=0,
//     dec_instr=0, occupancy=0, stall=0.
//   Accept: fetch accepted in cycle N iff stall=0 in N.
//     At edge N: infl_v<=1 and infl_pc<=fetch_pc.
//     If not accepted: infl_v<=0.
//   Response: in cycle N+1, if infl_v=1 and flush=0, write
//     {infl_pc, imem_rdata} at wr_ptr; wr_ptr++.
//   Latency: accept in N -> dec_valid=1 in N+2 (empty queue, dec_ready=1).
//   Stall: stall = (count + infl_v >= DEPTH) & ~flush.
//     - Combinational from registered state only; no path from dec_ready.
//     - The in-flight slot is reserved, so a write can never overflow.
//     - A pop in the same cycle does not lower stall; this is accepted
//       (conservative) behaviour.
//   Dequeue: dec_valid = (count != 0) & ~flush.
//     - dec_pc/dec_instr = storage[rd_ptr], driven combinationally from regs.
//     - Handshake (dec_valid & dec_ready) -> rd_ptr++.
//   Count: count += push - pop. Simultaneous push and pop leaves count unchanged.
//   Pointers: PTR_W bits, wrap naturally modulo DEPTH.
//     Full  = count==DEPTH.  Empty = count==0.
//   Flush (cycle F):
//     - count, rd_ptr and wr_ptr are cleared to 0.
//     - The response arriving in F is dropped.
//     - dec_valid=0 in F, so no handshake completes in F.
//     - stall=0 in F, so the redirect target fetch_pc is always accepted:
//       infl_v<=1, infl_pc<=fetch_pc.
//     - First post-flush entry: dec_valid in F+2.
//   Back-to-back flush: each flush discards the previous target's in-flight
//     fetch; only the last target survives.
//   Reset mid-operation: all state clears immediately, regardless of clk.
//     The first fetch is accepted in the first cycle with rst=1.
//   dec_pc/dec_instr are don't-care when dec_valid=0; the bench must not
//     check them in that case.
// TESTING
//   1 Stream: reset, fetch_pc 0x40000000,+4,... with dec_ready=1 ->
//     dec_valid from cycle 2; dec_pc 0x40000000,04,08 in order with
//     matching imem_rdata; stall stays 0.
//   2 Backpressure, DEPTH=4, dec_ready=0 ->
//     - stall=1 once count+infl_v=4; occupancy=4; no entry lost.
//     - Raise dec_ready -> entries drain in order; stall drops the cycle
//       after the first pop.
//   3 Flush with 3 queued + 1 in flight, flush=1, fetch_pc=0x40000100 ->
//     - occupancy=0 and dec_valid=0 in F.
//     - Next entry dec_pc=0x40000100 at F+2.
//     - No pre-flush PC ever appears at decode.
//   4 Flush while full and stalled -> stall=0 in F; target accepted; no overflow.
//   5 Flush at F and F+1 (targets 0x100, 0x200) -> only 0x200 reaches
//     decode, at F+3.
//   6 Assert rst=0 between clock edges mid-stream ->
//     - Outputs clear asynchronously.
//     - After release, the first fetch_pc is delivered first.
//     - The wrap-around pointer sequence across 10+ entries stays ordered.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: pairs each accepted fetch PC with the IMEM word returned one cycle later and queues {pc, instr} for decode.
// Latency: a fetch accepted in cycle N reaches decode (dec_valid) in cycle N+2 when the queue is empty.
// Backpressure: stall holds the PC once queued + in-flight entries reach DEPTH; a flush empties everything and always accepts the target.
module fetch_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      imem_rdata,
  input  logic             flush,
  output logic             stall,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_pc,
  output logic [31:0]      dec_instr,
  output logic [CNT_W-1:0] occupancy
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Queue bookkeeping and the single outstanding IMEM request.
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             infl_v_q, infl_v_d;
  logic [31:0]      infl_pc_q, infl_pc_d;
  entry_t           mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W:0]   reserved;
  entry_t           head;

  // Output and handshake decode, purely from registered state plus flush.
  // The in-flight request counts against capacity, so the response that
  // arrives next cycle always has a free slot. dec_ready is deliberately
  // kept out of stall: a same-cycle pop does not release the PC.
  always_comb begin
    reserved  = {1'b0, count_q} + (CNT_W + 1)'(infl_v_q);
    stall     = (reserved >= (CNT_W + 1)'(DEPTH)) & ~flush;
    dec_valid = (count_q != '0) & ~flush;
    push      = infl_v_q & ~flush;
    pop       = dec_valid & dec_ready;
    head      = mem_q[rd_ptr_q];
    dec_pc    = head.pc;
    dec_instr = head.instr;
    // Entries being discarded by a flush are no longer reported as queued.
    occupancy = flush ? '0 : count_q;
  end

  // Next-state for pointers, count and the in-flight request.
  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    infl_v_d  = ~stall;
    infl_pc_d = stall ? infl_pc_q : fetch_pc;
    if (flush) begin
      // Redirect: drop the queue and the response arriving now; the new
      // target is accepted this cycle because stall is forced low.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      infl_v_q  <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      infl_v_q  <= infl_v_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  // Entry storage: the returning IMEM word is paired with the PC that requested it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {infl_pc_q, imem_rdata};
    end
  end

endmodule
